// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with a fetch/execute FSM.
// Ports:
//   Clock, nReset                   clock, asynchronous active-low reset
//   imem_req, imem_addr             fetch request and address (address is the PC)
//   imem_valid, imem_data           program memory response
//   instr, instr_valid              instruction register and its execute qualifier
//   stall                           datapath not ready; hold the current instruction
//   PCincr, PCabsbranch, PCrelbranch, Branchaddr   decoder PC controls
//   pc, halted, icount              PC, halt flag, retired-instruction count
module pc_sequencer #(
  parameter int unsigned PSIZE = 8,
  parameter int unsigned ISIZE = 20
) (
  input  logic             Clock,
  input  logic             nReset,
  output logic             imem_req,
  output logic [PSIZE-1:0] imem_addr,
  input  logic             imem_valid,
  input  logic [ISIZE-1:0] imem_data,
  output logic [ISIZE-1:0] instr,
  output logic             instr_valid,
  input  logic             stall,
  input  logic             PCincr,
  input  logic             PCabsbranch,
  input  logic             PCrelbranch,
  input  logic [PSIZE-1:0] Branchaddr,
  output logic [PSIZE-1:0] pc,
  output logic             halted,
  output logic [15:0]      icount
);

  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t           r_state;
  logic [PSIZE-1:0] r_pc;
  logic [ISIZE-1:0] r_instr;
  logic [CW-1:0]    r_icount;

  // Status outputs decode the state register only, so none follows an input.
  assign imem_req    = (r_state == FETCH);
  assign instr_valid = (r_state == EXEC);
  assign halted      = (r_state == HALT);
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign instr       = r_instr;
  assign icount      = r_icount;

  // Sequencer FSM with PC, instruction and retire-count registers.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_state  <= IDLE;
      r_pc     <= '0;
      r_instr  <= '0;
      r_icount <= '0;
    end else begin
      case (r_state)
        IDLE: r_state <= FETCH;

        FETCH: begin
          if (imem_valid) begin
            r_instr <= imem_data;
            r_state <= EXEC;
          end
        end

        EXEC: begin
          if (!stall) begin
            // Retire counter saturates instead of wrapping.
            if (r_icount != {CW{1'b1}}) r_icount <= r_icount + CW'(1);
            r_state <= FETCH;
            if (PCabsbranch)      r_pc <= Branchaddr;
            else if (PCrelbranch) r_pc <= r_pc + Branchaddr; // two's-complement add wraps modulo 2^PSIZE
            else if (PCincr)      r_pc <= r_pc + PSIZE'(1);
            else                  r_state <= HALT;
          end
        end

        HALT: r_state <= HALT;

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        Clock = 1'b0;
  logic        nReset;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_valid;
  logic [19:0] imem_data;
  logic [19:0] instr;
  logic        instr_valid;
  logic        stall;
  logic        PCincr, PCabsbranch, PCrelbranch;
  logic [7:0]  Branchaddr;
  logic [7:0]  pc;
  logic        halted;
  logic [15:0] icount;

  int tests = 0;
  int fails = 0;

  pc_sequencer #(.PSIZE(8), .ISIZE(20)) dut (
    .Clock(Clock), .nReset(nReset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_data(imem_data),
    .instr(instr), .instr_valid(instr_valid),
    .stall(stall), .PCincr(PCincr), .PCabsbranch(PCabsbranch),
    .PCrelbranch(PCrelbranch), .Branchaddr(Branchaddr),
    .pc(pc), .halted(halted), .icount(icount)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one full cycle; inputs are driven and outputs sampled at the falling edge.
  task automatic tick();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  initial begin
    nReset = 1'b0; imem_valid = 1'b0; imem_data = '0; stall = 1'b0;
    PCincr = 1'b0; PCabsbranch = 1'b0; PCrelbranch = 1'b0; Branchaddr = '0;
    tick(); tick();
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_instr", 32'(instr), 32'h0);
    chk("rst_icount", 32'(icount), 32'h0);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_ivalid", 32'(instr_valid), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);

    // Zero-wait memory, PCincr every instruction.
    nReset = 1'b1;
    imem_valid = 1'b1; imem_data = 20'h11111; PCincr = 1'b1;
    chk("idle_req", 32'(imem_req), 32'h0);
    tick();
    chk("f0_req", 32'(imem_req), 32'h1);
    chk("f0_addr", 32'(imem_addr), 32'h0);
    tick();
    chk("e0_ivalid", 32'(instr_valid), 32'h1);
    chk("e0_req", 32'(imem_req), 32'h0);
    chk("e0_instr", 32'(instr), 32'h11111);
    imem_data = 20'h22222;
    tick();
    chk("f1_addr", 32'(imem_addr), 32'h1);
    chk("f1_req", 32'(imem_req), 32'h1);
    chk("f1_icount", 32'(icount), 32'h1);
    tick(); tick();
    chk("f2_addr", 32'(imem_addr), 32'h2);
    tick();
    chk("e2_instr", 32'(instr), 32'h22222);
    tick();
    chk("f3_addr", 32'(imem_addr), 32'h3);
    chk("f3_icount", 32'(icount), 32'h3);

    // Memory valid delayed by three cycles.
    imem_valid = 1'b0; imem_data = 20'h0BAD0;
    for (int i = 0; i < 3; i++) begin
      chk("wait_req", 32'(imem_req), 32'h1);
      chk("wait_addr", 32'(imem_addr), 32'h3);
      tick();
    end
    imem_valid = 1'b1; imem_data = 20'hABCDE;
    chk("wait_req4", 32'(imem_req), 32'h1);
    chk("wait_addr4", 32'(imem_addr), 32'h3);
    tick();
    imem_valid = 1'b0; imem_data = 20'h55555;
    chk("dly_instr", 32'(instr), 32'hABCDE);
    chk("dly_ivalid", 32'(instr_valid), 32'h1);

    // Stall holds EXEC for three cycles; controls ignored meanwhile.
    stall = 1'b1; PCabsbranch = 1'b1; Branchaddr = 8'h99;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stl_ivalid", 32'(instr_valid), 32'h1);
      chk("stl_pc", 32'(pc), 32'h3);
      chk("stl_icount", 32'(icount), 32'h3);
      chk("stl_instr", 32'(instr), 32'hABCDE);
    end
    stall = 1'b0; PCabsbranch = 1'b0;
    tick();
    chk("unstl_pc", 32'(pc), 32'h4);
    chk("unstl_icount", 32'(icount), 32'h4);
    chk("unstl_req", 32'(imem_req), 32'h1);

    // Step to pc=5, then relative branch by -2.
    imem_valid = 1'b1;
    tick(); tick();
    chk("pc5", 32'(pc), 32'h5);
    tick();
    PCincr = 1'b0; PCrelbranch = 1'b1; Branchaddr = 8'hFE;
    tick();
    chk("rel_pc", 32'(pc), 32'h3);
    chk("rel_icount", 32'(icount), 32'h6);
    tick();
    PCrelbranch = 1'b0; PCabsbranch = 1'b1; Branchaddr = 8'hFF;
    tick();
    chk("abs_pc", 32'(pc), 32'hFF);
    tick();
    PCabsbranch = 1'b0; PCincr = 1'b1;
    tick();
    chk("wrap_pc", 32'(pc), 32'h00);
    tick();
    PCincr = 1'b0; PCabsbranch = 1'b1; PCrelbranch = 1'b1; Branchaddr = 8'h40;
    tick();
    chk("prio_pc", 32'(pc), 32'h40);
    chk("prio_icount", 32'(icount), 32'h9);

    // No control -> halt; later valid pulses ignored.
    imem_data = 20'h77777;
    tick();
    PCabsbranch = 1'b0; PCrelbranch = 1'b0;
    chk("pre_halt_instr", 32'(instr), 32'h77777);
    tick();
    chk("halt_flag", 32'(halted), 32'h1);
    chk("halt_req", 32'(imem_req), 32'h0);
    chk("halt_ivalid", 32'(instr_valid), 32'h0);
    chk("halt_pc", 32'(pc), 32'h40);
    chk("halt_icount", 32'(icount), 32'hA);
    imem_data = 20'h12345;
    for (int i = 0; i < 4; i++) begin
      imem_valid = (i % 2 == 0);
      tick();
    end
    chk("halt_hold", 32'(halted), 32'h1);
    chk("halt_req2", 32'(imem_req), 32'h0);
    chk("halt_instr", 32'(instr), 32'h77777);
    chk("halt_icount2", 32'(icount), 32'hA);

    // Reach FETCH at pc=7, then reset mid-fetch.
    nReset = 1'b0; tick();
    nReset = 1'b1; imem_valid = 1'b1; PCabsbranch = 1'b1; Branchaddr = 8'h07;
    tick(); tick(); tick();
    imem_valid = 1'b0; PCabsbranch = 1'b0;
    chk("f7_req", 32'(imem_req), 32'h1);
    chk("f7_addr", 32'(imem_addr), 32'h7);
    #2 nReset = 1'b0;
    #1;
    chk("arst_pc", 32'(pc), 32'h0);
    chk("arst_req", 32'(imem_req), 32'h0);
    chk("arst_instr", 32'(instr), 32'h0);
    chk("arst_icount", 32'(icount), 32'h0);
    @(negedge Clock);
    nReset = 1'b1; imem_valid = 1'b1; imem_data = 20'h3C3C3;
    chk("rel_idle_req", 32'(imem_req), 32'h0);
    tick();
    chk("rel_f_req", 32'(imem_req), 32'h1);
    chk("rel_f_addr", 32'(imem_addr), 32'h0);
    chk("rel_f_instr", 32'(instr), 32'h0);
    imem_valid = 1'b0;
    tick();
    chk("rel_f_hold", 32'(imem_req), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter PSIZE, default 8, program-counter / program-address width.
REQ-002 Parameter ISIZE, default 20, instruction word width.
REQ-003 Clock  input  1  single clock; all state changes on its rising edge.
REQ-004 nReset  input  1  asynchronous, active-low reset.
REQ-005 imem_req  output  1  fetch request to program memory.
REQ-006 imem_addr  output  PSIZE  fetch address, equal to PC.
REQ-007 imem_valid  input  1  program memory returns data this cycle.
REQ-008 imem_data  input  ISIZE  instruction word from program memory.
REQ-009 instr  output  ISIZE  instruction register, fed to the decoder and datapath.
REQ-010 instr_valid  output  1  instr is held and decoder controls are being sampled.
REQ-011 stall  input  1  datapath not ready; hold the current instruction.
REQ-012 PCincr, PCabsbranch, PCrelbranch  input  1 each  decoder PC controls.
REQ-013 Branchaddr  input  PSIZE  absolute target or two's-complement relative offset.
REQ-014 pc  output  PSIZE  current program counter.
REQ-015 halted  output  1  sequencer stopped.
REQ-016 icount  output  16  retired-instruction count.

Function
REQ-017 The FSM SHALL have the states IDLE, FETCH, EXEC and HALT.
REQ-018 IDLE SHALL last exactly one cycle after reset release, then move to FETCH.
REQ-019 FETCH SHALL assert imem_req=1 with imem_addr=pc held stable until the cycle imem_valid=1.
REQ-020 In the FETCH cycle with imem_valid=1, instr SHALL capture imem_data and the state SHALL move to EXEC; imem_req SHALL drop in the next cycle.
REQ-021 imem_valid SHALL be ignored in every state other than FETCH.
REQ-022 EXEC SHALL assert instr_valid=1; imem_req=0.
REQ-023 In EXEC with stall=1, state, pc, instr and icount SHALL be held and the PC controls ignored.
REQ-024 In EXEC with stall=0, pc SHALL update per REQ-025..028 on the same edge, icount SHALL increment, and the state SHALL move to FETCH, unless REQ-028 applies.
REQ-025 PCabsbranch=1: pc <= Branchaddr; this has highest priority.
REQ-026 Else PCrelbranch=1: pc <= pc + Branchaddr, treated as a signed offset and computed modulo 2^PSIZE.
REQ-027 Else PCincr=1: pc <= pc + 1, wrapping from 2^PSIZE-1 to 0.
REQ-028 No control asserted: pc held, icount incremented, and the state moves to HALT.
REQ-029 HALT SHALL be terminal until reset; halted=1, imem_req=0, instr_valid=0.
REQ-030 icount SHALL saturate at 16'hFFFF.
REQ-031 Minimum cycles per instruction SHALL be 2: one FETCH cycle with imem_valid, then one EXEC cycle.
REQ-032 All outputs SHALL be registered or decoded from the state register only; none SHALL depend combinationally on inputs.

Reset
REQ-033 nReset=0 SHALL immediately force: state IDLE, pc=0, instr=0, icount=0, imem_req=0, instr_valid=0, halted=0.
REQ-034 Reset asserted mid-fetch SHALL abandon the request; an imem_valid arriving after release but before the new FETCH SHALL be ignored.

Verification
REQ-035 Reset release, memory returning valid in the same cycle as req, PCincr=1 each EXEC -> imem_addr 0,1,2,3 in successive FETCH cycles; exactly 2 cycles per instruction; icount=3 after the third EXEC.
REQ-036 imem_valid delayed 3 cycles -> imem_req held and imem_addr stable for 4 cycles; instr equals the data delivered in the valid cycle.
REQ-037 pc=8'h05, PCrelbranch=1, Branchaddr=8'hFE -> next pc=8'h03; pc=8'hFF with PCincr -> pc=8'h00; PCabsbranch=1 and PCrelbranch=1 together with Branchaddr=8'h40 -> pc=8'h40.
REQ-038 stall=1 for 3 EXEC cycles -> instr_valid stays 1, pc and icount unchanged; advance occurs on the first edge with stall=0.
REQ-039 EXEC with no PC control asserted -> halted=1 and imem_req=0 permanently; subsequent imem_valid pulses are ignored.
REQ-040 nReset pulsed low during FETCH with pc=8'h07 -> outputs reset asynchronously; after release, IDLE for one cycle, then FETCH at imem_addr=0.
